// File: rtl/logic_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_arb_pkg
// Purpose  : Shared definitions for the logic-unit arbiter. Holds the datapath
//            width, the operation type and the operation encodings.
// Ports    : none (package)
// Config   : LOGIC_ARB_STATS_EN is consumed by logic_unit_arbiter, not here.
// Revision : 1.0  initial release
// ============================================================================
package logic_arb_pkg;

   localparam int DATA_W = 64;

   typedef logic [1:0] logic_op_t;

   localparam logic_op_t LOP_AND = 2'b00;
   localparam logic_op_t LOP_OR  = 2'b01;
   localparam logic_op_t LOP_XOR = 2'b10;
   localparam logic_op_t LOP_ILL = 2'b11;

endpackage : logic_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Grants the first asserted
//            request at or after ptr, searching upward and wrapping.
// Ports    : req     in  NUM_REQ  request vector
//            en      in  1        grants allowed this cycle
//            ptr     in  ID_W     highest-priority index
//            gnt     out NUM_REQ  one-hot grant (all-zero when en=0)
//            gnt_idx out ID_W     encoded index of gnt (0 when no grant)
// Config   : none
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx
);

   // Walk the offsets from farthest to nearest; the last hit wins, so the
   // nearest asserted request to ptr ends up granted.
   always_comb begin
      int              idx;
      logic [ID_W-1:0] idx_l;
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      idx_l   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         idx_l = ID_W'(idx);
         if (en && req[idx_l]) begin
            gnt        = '0;
            gnt[idx_l] = 1'b1;
            gnt_idx    = idx_l;
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : Shares one 64-bit AND/OR/XOR datapath between NUM_REQ
//            requesters with round-robin arbitration and a single registered
//            response stage tagged with the requester id.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready  per-requester handshake (ready is one-hot)
//            req_op  [2i+:2]      00 AND, 01 OR, 10 XOR, 11 illegal
//            req_a/req_b [64i+:64] operands
//            rsp_valid/rsp_ready  response handshake
//            rsp_result, rsp_id, rsp_err  response payload
//            grant_cnt [32i+:32]  per-requester accepted count (stats only)
// Config   : LOGIC_ARB_STATS_EN  adds grant_cnt port and its counters
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_arbiter
   import logic_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [2*NUM_REQ-1:0]      req_op,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_result,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      rsp_err
`ifdef LOGIC_ARB_STATS_EN
   ,
   output logic [32*NUM_REQ-1:0]     grant_cnt
`endif
);

   logic                 accept;
   logic [NUM_REQ-1:0]   gnt;
   logic [ID_W-1:0]      gnt_idx;
   logic                 xfer;

   logic_op_t            sel_op;
   logic [DATA_W-1:0]    sel_a;
   logic [DATA_W-1:0]    sel_b;
   logic [DATA_W-1:0]    sel_res;

   logic                 rsp_valid_q,  rsp_valid_d;
   logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
   logic [ID_W-1:0]      rsp_id_q,     rsp_id_d;
   logic                 rsp_err_q,    rsp_err_d;
   logic [ID_W-1:0]      rr_ptr_q,     rr_ptr_d;

   // The response slot can take a new result when it is empty or being
   // drained this cycle.
   assign accept = ~rsp_valid_q | rsp_ready;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req     (req_valid),
      .en      (accept),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;

   // One-hot select: only the granted slice is ever routed, so unknowns on
   // idle ports cannot leak into the result.
   always_comb begin
      sel_op = LOP_AND;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_op = req_op[2*i +: 2];
            sel_a  = req_a[DATA_W*i +: DATA_W];
            sel_b  = req_b[DATA_W*i +: DATA_W];
         end
      end
   end

   always_comb begin
      case (sel_op)
         LOP_AND: sel_res = sel_a & sel_b;
         LOP_OR:  sel_res = sel_a | sel_b;
         LOP_XOR: sel_res = sel_a ^ sel_b;
         default: sel_res = '0;
      endcase
   end

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_id_d     = rsp_id_q;
      rsp_err_d    = rsp_err_q;
      rr_ptr_d     = rr_ptr_q;
      if (xfer) begin
         rsp_valid_d  = 1'b1;
         rsp_result_d = sel_res;
         rsp_id_d     = gnt_idx;
         rsp_err_d    = (sel_op == LOP_ILL);
         rr_ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_id_q     <= '0;
         rsp_err_q    <= 1'b0;
         rr_ptr_q     <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_id_q     <= rsp_id_d;
         rsp_err_q    <= rsp_err_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_err    = rsp_err_q;

`ifdef LOGIC_ARB_STATS_EN
   // Free-running per-requester transfer counters; wrap naturally at 2^32.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [31:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (gnt[gi]) begin
            cnt_d = cnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign grant_cnt[32*gi +: 32] = cnt_q;
   end
`endif

endmodule : logic_unit_arbiter
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Purpose  : Self-checking bench for logic_unit_arbiter: directed scenarios
//            with literal expectations followed by randomized traffic checked
//            against a transaction-level model of the arbiter.
// Config   : LOGIC_ARB_STATS_EN enables grant_cnt checks
// Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [2*N-1:0] req_op;
   logic [64*N-1:0] req_a;
   logic [64*N-1:0] req_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [63:0]    rsp_result;
   logic [1:0]     rsp_id;
   logic           rsp_err;
`ifdef LOGIC_ARB_STATS_EN
   logic [32*N-1:0] grant_cnt;
`endif

   logic_unit_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_id     (rsp_id),
      .rsp_err    (rsp_err)
`ifdef LOGIC_ARB_STATS_EN
      ,
      .grant_cnt  (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Transaction-level model state
   bit          m_valid;
   logic [63:0] m_res;
   int          m_id;
   bit          m_err;
   int          m_ptr;
   int unsigned m_cnt [N];

   int          last_grant;
   logic [N-1:0] seen_rdy;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] op_result(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      if (op == 2'd0) return a & b;
      if (op == 2'd1) return a | b;
      if (op == 2'd2) return a ^ b;
      return 64'd0;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_res = '0; m_id = 0; m_err = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      req_valid[i]       = 1'b1;
      req_op[2*i +: 2]   = op;
      req_a[64*i +: 64]  = a;
      req_b[64*i +: 64]  = b;
   endtask

   // One clock cycle: entered at posedge+1 with inputs applied, compares the
   // DUT against the model before the next edge, then advances the model.
   task automatic step();
      int          g;
      logic [N-1:0] exp_rdy;
      logic [1:0]  op;
      logic [63:0] a, b;
      #3;
      g = -1;
      exp_rdy = '0;
      if (!m_valid || rsp_ready) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 128'(req_ready), 128'(exp_rdy));
      check("rsp_valid", 128'(rsp_valid), 128'(m_valid));
      if (m_valid) begin
         check("rsp_result", 128'(rsp_result), 128'(m_res));
         check("rsp_id",     128'(rsp_id),     128'(m_id));
         check("rsp_err",    128'(rsp_err),    128'(m_err));
      end
`ifdef LOGIC_ARB_STATS_EN
      for (int i = 0; i < N; i++) check("grant_cnt", 128'(grant_cnt[32*i +: 32]), 128'(m_cnt[i]));
`endif
      seen_rdy   = req_ready;
      last_grant = g;
      if (g >= 0) begin
         op = req_op[2*g +: 2];
         a  = req_a[64*g +: 64];
         b  = req_b[64*g +: 64];
      end
      @(posedge clk);
      if (g >= 0) begin
         m_valid = 1;
         m_res   = op_result(op, a, b);
         m_id    = g;
         m_err   = (op == 2'b11);
         m_ptr   = (g + 1) % N;
         m_cnt[g]++;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
      #1;
      if (g >= 0) begin
         req_valid[g]      = 1'b0;
         req_op[2*g +: 2]  = 'x;
         req_a[64*g +: 64] = 'x;
         req_b[64*g +: 64] = 'x;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_op    = 'x;
      req_a     = 'x;
      req_b     = 'x;
      rsp_ready = 1'b1;
      model_reset();
      do_reset();

      // Reset values
      #2;
      check("reset_rsp_valid",  128'(rsp_valid),  128'(0));
      check("reset_rsp_result", 128'(rsp_result), 128'(0));
      check("reset_rsp_id",     128'(rsp_id),     128'(0));
      check("reset_rsp_err",    128'(rsp_err),    128'(0));
`ifdef LOGIC_ARB_STATS_EN
      check("reset_grant_cnt",  128'(grant_cnt),  128'(0));
`endif
      @(posedge clk); #1;

      // Reset while a response is held
      rsp_ready = 1'b0;
      set_req(2, 2'b00, 64'h1234, 64'hFFFF);
      step();
      step();
      check("held_rsp_valid", 128'(rsp_valid), 128'(1));
      #1;
      rst = 1'b1;
      #1;
      check("async_reset_rsp_valid", 128'(rsp_valid), 128'(0));
      model_reset();
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;

      // Round robin with all requesters continuously valid
      for (int c = 0; c < 5; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) set_req(i, 2'(i % 3), 64'(c * 16 + i), 64'hFFFF_FFFF_FFFF_FFFF);
         end
         step();
         check("rr_order", 128'(last_grant), 128'(c % N));
      end
      req_valid = '0;
      step();

      // Single AND from requester 1, then hold it under backpressure
      set_req(1, 2'b00, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
      step();
      rsp_ready = 1'b0;
      set_req(2, 2'b10, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000);
      #2;
      check("single_rsp_valid",  128'(rsp_valid),  128'(1));
      check("single_rsp_result", 128'(rsp_result), 128'(64'hF000_F000_F000_F000));
      check("single_rsp_id",     128'(rsp_id),     128'(1));
      check("single_rsp_err",    128'(rsp_err),    128'(0));
      #(-0); // keep alignment explicit: still posedge+3 region below
      for (int c = 0; c < 3; c++) begin
         step();
         check("bp_no_grant", 128'(seen_rdy),   128'(0));
         check("bp_hold",     128'(rsp_result), 128'(64'hF000_F000_F000_F000));
      end
      rsp_ready = 1'b1;
      step();
      check("bp_release_grant", 128'(seen_rdy),   128'(4'b0100));
      check("xor_result",       128'(rsp_result), 128'(64'hFEDC_4567_7654_CDEF));
      check("xor_id",           128'(rsp_id),     128'(2));

      // Illegal op from requester 3; pointer must wrap to 0
      set_req(3, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      step();
      check("ill_err",    128'(rsp_err),    128'(1));
      check("ill_result", 128'(rsp_result), 128'(0));
      check("ill_id",     128'(rsp_id),     128'(3));
      for (int i = 0; i < N; i++) set_req(i, 2'b01, 64'h5, 64'hA);
      step();
      check("ill_ptr_wrap", 128'(seen_rdy), 128'(4'b0001));
      req_valid = '0;
      step();

`ifdef LOGIC_ARB_STATS_EN
      // Counter totals after a known grant mix
      do_reset();
      for (int c = 0; c < 5; c++) begin
         set_req(0, 2'b00, 64'h1, 64'h1);
         step();
      end
      for (int c = 0; c < 2; c++) begin
         set_req(2, 2'b00, 64'h1, 64'h1);
         step();
      end
      check("stats_totals", 128'(grant_cnt), 128'({32'd0, 32'd2, 32'd0, 32'd5}));
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               set_req(i, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_logic_unit_arbiter
`default_nettype wire
